alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Registered, parametrised ALU with a valid/ready handshake and a persistent NZCV flag register.
- Supports conditional execution against the stored flags, an opt-in flag-update bit, and a multi-cycle iterative multiplier.
- Sits between decode and register-file writeback; executes the 16-entry 4-bit opcode set at configurable datapath width.

Parameters:
- WIDTH, 32, datapath width; power of two, 8..64.
- SHW, $clog2(WIDTH), shift-amount width; taken from imm[3+SHW-1:3].

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation.
- op_code  in  4  operation select.
- cond  in  4  required NZCV; 0 = always execute.
- set_flags  in  1  allow flag update for non-CMP flag ops.
- src1  in  WIDTH  operand 1.
- src2  in  WIDTH  operand 2.
- imm  in  16  immediate / shift field.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- reg_write  out  1  writeback enable, qualified by out_valid.
- cond_fail  out  1  op skipped because cond did not match.
- flags  out  4  NZCV register.
- busy  out  1  multiply in progress.

Behaviour:
- Reset (async): state=IDLE, out_valid=0, result=0, reg_write=0, cond_fail=0, flags=0, busy=0, multiply counter/accumulator=0.
  - Reset mid-multiply aborts the operation; no output is produced.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Accept occurs when in_valid && in_ready. Operands are captured at accept.
- Condition check at accept, using the flags register value at that edge: execute iff cond==0 or cond==flags.
  - On fail: out_valid next cycle, cond_fail=1, reg_write=0, result=0, flags unchanged.
- Latency:
  - Single-cycle ops: out_valid asserted the cycle after accept.
  - MUL: state=MUL, busy=1 for WIDTH cycles (shift-add, one bit per cycle), then out_valid. in_ready=0 throughout.
- out_valid, result, reg_write, cond_fail are held until out_valid && out_ready. A new accept on that same edge is allowed, giving back-to-back throughput of 1/cycle.
- Flags register updates on the same edge result is registered, so the next accepted op sees the updated flags.
- Ops (reg_write in brackets):
  - 0 ADD: {C,res}=src1+src2; V=signed overflow (operand signs equal, result sign differs). [1]
  - 1 SUB: res=src1-src2; C=borrow (src1<src2 unsigned); V=(src1 sign!=src2 sign) && (res sign!=src1 sign). [1]
  - 2 MUL: res=low WIDTH bits of product; C=1 if any high product bit nonzero; V=0. [1]
  - 3 OR, 4 AND, 5 XOR: bitwise; flags never change. [1]
  - 6 MOVI: res=zero-extended imm. [1]
  - 7 MOV: res=src1. [1]
  - 8 LSR: res=src1>>sh; C=last bit shifted out. [1]
  - 9 LSL: res=src2<<sh; C=last bit shifted out. [1]
  - A ROR: res=src1 rotated right by sh; C=last bit rotated out. [1]
  - B CMP: SUB flags, res=src1-src2. [0]
  - C LDA: res=zero-extended imm. [1]
  - D LD: res=src1 (address pass-through). [1]
  - E ST: res=src1. [0]
  - F NOP: res=0. [0]
- Shifts: sh=imm[3+SHW-1:3]. sh=0 gives res=src and C=0. V=0 for all shifts.
- Flag rules:
  - N=res[WIDTH-1], Z=(res==0).
  - CMP always writes flags when executed.
  - ADD, SUB, MUL, LSR, LSL, ROR write flags only when set_flags=1 (captured at accept).
  - All other ops never modify flags.
- in_valid while !in_ready: input ignored; upstream must hold it.

Test Plan:
- WIDTH=32, ADD 0xFFFFFFFF+0x1, set_flags=1, cond=0 -> next cycle result=0, reg_write=1, flags=0110. Repeat with set_flags=0 -> flags unchanged.
- ADD 0x7FFFFFFF+0x1, set_flags=1 -> result=0x80000000, flags=1001. Then SUB 0x80000000-0x1 -> result=0x7FFFFFFF, flags=0001.
- MUL 1234*5678 -> busy=1 and in_ready=0 for 32 cycles, then result=7006652 (0x006AE9BC), flags=0000 with set_flags=1. MUL 0x10000*0x10000 -> result=0, flags=0110.
- CMP 5,5 -> flags=0100, reg_write=0. ADD 1+2 with cond=0100 -> result=3, reg_write=1. ADD with cond=1000 -> cond_fail=1, reg_write=0, flags stay 0100.
- ROR 0x00000001 with imm=0x0008 (sh=1), set_flags=1 -> result=0x80000000, flags=1010. LSL 0x80000000 with imm=0x0008 -> result=0, flags=0110. LSR with sh=0 -> result=src1, C=0.
- Backpressure and reset:
  - out_ready=0 for 5 cycles -> result and out_valid stable, in_ready=0.
  - Assert rst mid-MUL -> out_valid=0, flags=0, busy=0 immediately; in_ready=1 after rst deasserts.

Source files
------------

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, persistent NZCV flags, conditional
// execution and an iterative shift-add multiplier (one multiplier bit per cycle).
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_code,
  input  logic [3:0]       cond,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [15:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             reg_write,
  output logic             cond_fail,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MOVI = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_LSR  = 4'h8;
  localparam logic [3:0] OP_LSL  = 4'h9;
  localparam logic [3:0] OP_ROR  = 4'hA;
  localparam logic [3:0] OP_CMP  = 4'hB;
  localparam logic [3:0] OP_LDA  = 4'hC;
  localparam logic [3:0] OP_LD   = 4'hD;
  localparam logic [3:0] OP_ST   = 4'hE;
  localparam logic [3:0] OP_NOP  = 4'hF;

  typedef enum logic [0:0] {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t             state_r;
  logic               out_valid_r;
  logic [WIDTH-1:0]   result_r;
  logic               reg_write_r;
  logic               cond_fail_r;
  logic [3:0]         flags_r;
  logic               busy_r;
  logic [SHW-1:0]     cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic               mul_sf_r;

  logic               accept_s;
  logic               cond_ok_s;
  logic [SHW-1:0]     sh_s;
  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     sub_s;
  logic [WIDTH:0]     lsr_s;
  logic [WIDTH:0]     lsl_s;
  logic [WIDTH-1:0]   ror_s;
  logic [WIDTH-1:0]   imm_ext_s;
  logic [WIDTH-1:0]   res_s;
  logic               c_s;
  logic               v_s;
  logic               wf_s;
  logic               rw_s;
  logic [3:0]         nzcv_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [3:0]         mul_flags_s;

  assign in_ready  = (state_r == IDLE) && (!out_valid_r || out_ready);
  assign accept_s  = in_valid && in_ready;
  assign cond_ok_s = (cond == 4'd0) || (cond == flags_r);

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign reg_write = reg_write_r;
  assign cond_fail = cond_fail_r;
  assign flags     = flags_r;
  assign busy      = busy_r;

  // Extra top/bottom bit on the shifters catches the last bit shifted out.
  assign sh_s      = imm[3+SHW-1:3];
  assign add_s     = {1'b0, src1} + {1'b0, src2};
  assign sub_s     = {1'b0, src1} - {1'b0, src2};
  assign lsr_s     = {src1, 1'b0} >> sh_s;
  assign lsl_s     = {1'b0, src2} << sh_s;
  assign ror_s     = WIDTH'({src1, src1} >> sh_s);
  assign imm_ext_s = WIDTH'(imm);

  // Single-cycle datapath: result, carry, overflow and flag/writeback qualifiers.
  always_comb begin
    res_s = {WIDTH{1'b0}};
    c_s   = 1'b0;
    v_s   = 1'b0;
    wf_s  = 1'b0;
    rw_s  = 1'b1;
    case (op_code)
      OP_ADD: begin
        res_s = add_s[WIDTH-1:0];
        c_s   = add_s[WIDTH];
        v_s   = (src1[WIDTH-1] == src2[WIDTH-1]) && (add_s[WIDTH-1] != src1[WIDTH-1]);
        wf_s  = set_flags;
      end
      OP_SUB: begin
        res_s = sub_s[WIDTH-1:0];
        c_s   = sub_s[WIDTH];
        v_s   = (src1[WIDTH-1] != src2[WIDTH-1]) && (sub_s[WIDTH-1] != src1[WIDTH-1]);
        wf_s  = set_flags;
      end
      OP_CMP: begin
        res_s = sub_s[WIDTH-1:0];
        c_s   = sub_s[WIDTH];
        v_s   = (src1[WIDTH-1] != src2[WIDTH-1]) && (sub_s[WIDTH-1] != src1[WIDTH-1]);
        wf_s  = 1'b1;
        rw_s  = 1'b0;
      end
      OP_MUL:  res_s = {WIDTH{1'b0}};
      OP_OR:   res_s = src1 | src2;
      OP_AND:  res_s = src1 & src2;
      OP_XOR:  res_s = src1 ^ src2;
      OP_MOVI: res_s = imm_ext_s;
      OP_MOV:  res_s = src1;
      OP_LSR: begin
        res_s = lsr_s[WIDTH:1];
        c_s   = lsr_s[0];
        wf_s  = set_flags;
      end
      OP_LSL: begin
        res_s = lsl_s[WIDTH-1:0];
        c_s   = lsl_s[WIDTH];
        wf_s  = set_flags;
      end
      OP_ROR: begin
        res_s = ror_s;
        c_s   = (sh_s != {SHW{1'b0}}) && ror_s[WIDTH-1];
        wf_s  = set_flags;
      end
      OP_LDA:  res_s = imm_ext_s;
      OP_LD:   res_s = src1;
      OP_ST: begin
        res_s = src1;
        rw_s  = 1'b0;
      end
      OP_NOP:  rw_s = 1'b0;
      default: rw_s = 1'b0;
    endcase
  end

  assign nzcv_s      = {res_s[WIDTH-1], res_s == {WIDTH{1'b0}}, c_s, v_s};
  assign prod_s      = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
  assign mul_flags_s = {prod_s[WIDTH-1], prod_s[WIDTH-1:0] == {WIDTH{1'b0}},
                        |prod_s[2*WIDTH-1:WIDTH], 1'b0};

  // Control FSM, multiplier iteration and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      reg_write_r <= 1'b0;
      cond_fail_r <= 1'b0;
      flags_r     <= 4'd0;
      busy_r      <= 1'b0;
      cnt_r       <= {SHW{1'b0}};
      acc_r       <= {(2*WIDTH){1'b0}};
      mcand_r     <= {(2*WIDTH){1'b0}};
      mplier_r    <= {WIDTH{1'b0}};
      mul_sf_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (!cond_ok_s) begin
              out_valid_r <= 1'b1;
              result_r    <= {WIDTH{1'b0}};
              reg_write_r <= 1'b0;
              cond_fail_r <= 1'b1;
            end else if (op_code == OP_MUL) begin
              state_r     <= MUL;
              busy_r      <= 1'b1;
              out_valid_r <= 1'b0;
              reg_write_r <= 1'b0;
              cond_fail_r <= 1'b0;
              cnt_r       <= {SHW{1'b0}};
              acc_r       <= {(2*WIDTH){1'b0}};
              mcand_r     <= {{WIDTH{1'b0}}, src1};
              mplier_r    <= src2;
              mul_sf_r    <= set_flags;
            end else begin
              out_valid_r <= 1'b1;
              result_r    <= res_s;
              reg_write_r <= rw_s;
              cond_fail_r <= 1'b0;
              if (wf_s) begin
                flags_r <= nzcv_s;
              end
            end
          end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            reg_write_r <= 1'b0;
            cond_fail_r <= 1'b0;
          end
        end
        MUL: begin
          acc_r    <= prod_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + {{(SHW-1){1'b0}}, 1'b1};
          // WIDTH is a power of two, so the final step is at count all-ones.
          if (cnt_r == {SHW{1'b1}}) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
            result_r    <= prod_s[WIDTH-1:0];
            reg_write_r <= 1'b1;
            cond_fail_r <= 1'b0;
            if (mul_sf_r) begin
              flags_r <= mul_flags_s;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus random ops checked
// against an arithmetic reference model of the op set and NZCV rules.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op_code = 4'h0;
  logic [3:0]  cond = 4'h0;
  logic        set_flags = 1'b0;
  logic [31:0] src1 = 32'h0;
  logic [31:0] src2 = 32'h0;
  logic [15:0] imm = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        reg_write;
  logic        cond_fail;
  logic [3:0]  flags;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] mflags = 4'h0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_code(op_code), .cond(cond), .set_flags(set_flags),
    .src1(src1), .src2(src2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .reg_write(reg_write), .cond_fail(cond_fail), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: plain 64-bit arithmetic, updates mflags like the flag register.
  task automatic model_op(input logic [3:0] op, input logic [3:0] cnd, input logic sf,
                          input logic [31:0] a, input logic [31:0] b, input logic [15:0] im,
                          output logic [31:0] res, output logic rw, output logic cf);
    logic [63:0] ux;
    longint sx;
    int sh;
    logic c, v, wf;
    sh = int'(im[7:3]);
    c = 1'b0; v = 1'b0; wf = 1'b0; rw = 1'b1; cf = 1'b0; res = 32'h0;
    if (cnd != 4'h0 && cnd != mflags) begin
      cf = 1'b1; rw = 1'b0;
    end else begin
      case (op)
        4'h0: begin
          ux = 64'(a) + 64'(b); res = ux[31:0]; c = ux[32];
          sx = longint'($signed(a)) + longint'($signed(b));
          v = (sx != longint'($signed(res))); wf = sf;
        end
        4'h1, 4'hB: begin
          ux = 64'(a) - 64'(b); res = ux[31:0]; c = (a < b);
          sx = longint'($signed(a)) - longint'($signed(b));
          v = (sx != longint'($signed(res)));
          wf = (op == 4'hB) ? 1'b1 : sf;
          rw = (op == 4'hB) ? 1'b0 : 1'b1;
        end
        4'h2: begin
          ux = 64'(a) * 64'(b); res = ux[31:0]; c = (ux[63:32] != 32'h0); wf = sf;
        end
        4'h3: res = a | b;
        4'h4: res = a & b;
        4'h5: res = a ^ b;
        4'h6, 4'hC: res = {16'h0, im};
        4'h7, 4'hD: res = a;
        4'h8: begin res = a >> sh; c = (sh == 0) ? 1'b0 : a[sh-1]; wf = sf; end
        4'h9: begin res = b << sh; c = (sh == 0) ? 1'b0 : b[32-sh]; wf = sf; end
        4'hA: begin
          res = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
          c = (sh == 0) ? 1'b0 : a[sh-1]; wf = sf;
        end
        4'hE: begin res = a; rw = 1'b0; end
        default: begin res = 32'h0; rw = 1'b0; end
      endcase
      if (wf) mflags = {res[31], res == 32'h0, c, v};
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [3:0] cnd,
                        input logic sf, input logic [31:0] a, input logic [31:0] b,
                        input logic [15:0] im);
    logic [31:0] er;
    logic erw, ecf;
    int n, busy_cnt, ready_bad;
    model_op(op, cnd, sf, a, b, im, er, erw, ecf);
    @(negedge clk);
    op_code = op; cond = cnd; set_flags = sf; src1 = a; src2 = b; imm = im;
    out_ready = 1'b1; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0; busy_cnt = 0; ready_bad = 0;
    while (!out_valid && n < 100) begin
      if (busy) busy_cnt++;
      if (busy && in_ready) ready_bad++;
      @(negedge clk); n++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_result"}, 64'(result), 64'(er));
    check({tag, "_regwr"}, 64'(reg_write), 64'(erw));
    check({tag, "_cfail"}, 64'(cond_fail), 64'(ecf));
    check({tag, "_flags"}, 64'(flags), 64'(mflags));
    if (op == 4'h2 && !ecf) begin
      check({tag, "_busycyc"}, 64'(busy_cnt), 64'd32);
      check({tag, "_rdybusy"}, 64'(ready_bad), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] era, erb, r1, r2;
    logic erwa, ecfa, erwb, ecfb;
    logic [3:0] op;
    logic [3:0] cnd;

    repeat (3) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_regwr", 64'(reg_write), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(in_ready), 64'd1);

    run_op("add_c", 4'h0, 4'h0, 1'b1, 32'hFFFF_FFFF, 32'h1, 16'h0);
    check("add_c_fl", 64'(flags), 64'h6);
    run_op("add_nf", 4'h0, 4'h0, 1'b0, 32'hFFFF_FFFF, 32'h1, 16'h0);
    run_op("add_v", 4'h0, 4'h0, 1'b1, 32'h7FFF_FFFF, 32'h1, 16'h0);
    check("add_v_fl", 64'(flags), 64'h9);
    run_op("sub_v", 4'h1, 4'h0, 1'b1, 32'h8000_0000, 32'h1, 16'h0);
    check("sub_v_fl", 64'(flags), 64'h1);
    run_op("mul1", 4'h2, 4'h0, 1'b1, 32'd1234, 32'd5678, 16'h0);
    check("mul1_res", 64'(result), 64'h006A_E9BC);
    run_op("mul2", 4'h2, 4'h0, 1'b1, 32'h1_0000, 32'h1_0000, 16'h0);
    check("mul2_fl", 64'(flags), 64'h6);
    run_op("cmp", 4'hB, 4'h0, 1'b0, 32'd5, 32'd5, 16'h0);
    check("cmp_fl", 64'(flags), 64'h4);
    run_op("add_cok", 4'h0, 4'h4, 1'b0, 32'd1, 32'd2, 16'h0);
    run_op("add_cfl", 4'h0, 4'h8, 1'b1, 32'd1, 32'd2, 16'h0);
    check("add_cfl_cf", 64'(cond_fail), 64'd1);
    run_op("ror", 4'hA, 4'h0, 1'b1, 32'h1, 32'h0, 16'h0008);
    check("ror_fl", 64'(flags), 64'hA);
    run_op("lsl", 4'h9, 4'h0, 1'b1, 32'h0, 32'h8000_0000, 16'h0008);
    run_op("lsr0", 4'h8, 4'h0, 1'b1, 32'h8000_1235, 32'h0, 16'h0007);
    run_op("movi", 4'h6, 4'h0, 1'b1, 32'h0, 32'h0, 16'hBEEF);
    run_op("st", 4'hE, 4'h0, 1'b1, 32'h1234, 32'h0, 16'h0);
    run_op("nop", 4'hF, 4'h0, 1'b1, 32'h1234, 32'h0, 16'h0);

    // Backpressure: first result held while the second op waits, then both move on one edge.
    model_op(4'h0, 4'h0, 1'b1, 32'd10, 32'd20, 16'h0, era, erwa, ecfa);
    model_op(4'h6, 4'h0, 1'b0, 32'h0, 32'h0, 16'h1234, erb, erwb, ecfb);
    @(negedge clk);
    check("bp_ready0", 64'(in_ready), 64'd1);
    op_code = 4'h0; cond = 4'h0; set_flags = 1'b1; src1 = 32'd10; src2 = 32'd20;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    op_code = 4'h6; set_flags = 1'b0; imm = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_result", 64'(result), 64'(era));
      check("bp_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_valid", 64'(out_valid), 64'd1);
    check("b2b_result", 64'(result), 64'(erb));
    check("b2b_regwr", 64'(reg_write), 64'(erwb));

    // Reset in the middle of a multiply.
    run_op("cmp2", 4'hB, 4'h0, 1'b0, 32'd7, 32'd7, 16'h0);
    @(negedge clk);
    op_code = 4'h2; cond = 4'h0; set_flags = 1'b1; src1 = 32'd3; src2 = 32'd4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("mr_busy0", 64'(busy), 64'd1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mr_valid", 64'(out_valid), 64'd0);
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_flags", 64'(flags), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mflags = 4'h0;
    #1;
    check("mr_ready", 64'(in_ready), 64'd1);
    repeat (40) @(negedge clk);
    check("mr_noout", 64'(out_valid), 64'd0);

    for (int i = 0; i < 150; i++) begin
      op  = 4'($urandom_range(0, 15));
      cnd = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      r1  = ($urandom_range(0, 4) == 0) ? 32'h7FFF_FFFF + 32'($urandom_range(0, 2)) : $urandom;
      r2  = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      run_op("rnd", op, cnd, 1'($urandom_range(0, 1)), r1, r2, 16'($urandom));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
